mdu_iterative: RTL and testbench

//  EX-stage multiply/divide unit owning the HI/LO registers. Executes MULT/MULTU/DIV/DIVU

---
 rtl/mdu_iterative.sv | 160 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO for the EX stage (shift-add multiply, restoring divide).
// Optional build macro MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU, divides stay iterative.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MDUStartE,
  input  logic [2:0]       MDUOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             MDUReadyE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mduStateT;

  mduStateT state, nextState;

  logic [CntW-1:0]  cnt;
  logic [WIDTH:0]   acc, accNext, addSum, mulSum, shifted, diff;
  logic [WIDTH-1:0] quo, quoNext, mcand;
  logic             divOp, negQ, negR, divZero;
  logic             isSignedOp, aNeg, bNeg, longStart;
  logic [WIDTH-1:0] aMag, bMag, quoRes, remRes;
  logic [DW-1:0]    prodMag, prodRes;

  // Signed ops run on magnitudes; the sign is restored when the result is written.
  assign isSignedOp = ~MDUOpE[0];
  assign aNeg = isSignedOp & SrcAE[WIDTH-1];
  assign bNeg = isSignedOp & SrcBE[WIDTH-1];
  assign aMag = aNeg ? -SrcAE : SrcAE;
  assign bMag = bNeg ? -SrcBE : SrcBE;

`ifdef MDU_FAST_MUL_EN
  logic [DW-1:0] fastMag, fastProd;
  assign longStart = MDUStartE & ~MDUOpE[2] & MDUOpE[1];
  assign fastMag = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
  assign fastProd = (aNeg ^ bNeg) ? -fastMag : fastMag;
`else
  assign longStart = MDUStartE & ~MDUOpE[2];
`endif

  // One iteration: acc is the partial product high half or the running remainder.
  always_comb begin
    addSum  = acc + {1'b0, mcand};
    mulSum  = quo[0] ? addSum : acc;
    shifted = {acc[WIDTH-1:0], quo[WIDTH-1]};
    diff    = shifted - {1'b0, mcand};
    accNext = acc;
    quoNext = quo;
    if (divOp) begin
      if (!diff[WIDTH]) begin
        accNext = diff;
        quoNext = {quo[WIDTH-2:0], 1'b1};
      end else begin
        accNext = shifted;
        quoNext = {quo[WIDTH-2:0], 1'b0};
      end
    end else begin
      accNext = {1'b0, mulSum[WIDTH:1]};
      quoNext = {mulSum[0], quo[WIDTH-1:1]};
    end
  end

  // Final-iteration results with sign correction; zero divisor forces an all-ones quotient.
  always_comb begin
    prodMag = {accNext[WIDTH-1:0], quoNext};
    prodRes = negQ ? -prodMag : prodMag;
    quoRes  = divZero ? {WIDTH{1'b1}} : (negQ ? -quoNext : quoNext);
    remRes  = negR ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    MDUReadyE = 1'b1;
    case (state)
      IDLE: begin
        if (longStart) begin
          nextState = BUSY;
          MDUReadyE = 1'b0;
        end
      end
      BUSY: begin
        MDUReadyE = 1'b0;
        if (cnt == LastCnt) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (!rst_n) MDUReadyE = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HiE     <= '0;
      LoE     <= '0;
      acc     <= '0;
      quo     <= '0;
      mcand   <= '0;
      cnt     <= '0;
      divOp   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MDUStartE) begin
            if (longStart) begin
              acc     <= '0;
              quo     <= aMag;
              mcand   <= bMag;
              cnt     <= '0;
              divOp   <= MDUOpE[1];
              negQ    <= aNeg ^ bNeg;
              negR    <= aNeg;
              divZero <= MDUOpE[1] & (SrcBE == '0);
            end
`ifdef MDU_FAST_MUL_EN
            else if (MDUOpE[2:1] == 2'b00) begin
              {HiE, LoE} <= fastProd;
            end
`endif
            else if (MDUOpE == 3'b100) begin
              HiE <= SrcAE;
            end else if (MDUOpE == 3'b101) begin
              LoE <= SrcAE;
            end
          end
        end
        BUSY: begin
          acc <= accNext;
          quo <= quoNext;
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            if (divOp) begin
              HiE <= remRes;
              LoE <= quoRes;
            end else begin
              {HiE, LoE} <= prodRes;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table plus hand sequences, checked through a scoreboard.
module tb_mdu_iterative;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         MDUStartE;
  logic [2:0]   MDUOpE;
  logic [W-1:0] SrcAE, SrcBE;
  logic         MDUReadyE;
  logic [W-1:0] HiE, LoE;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .MDUStartE(MDUStartE), .MDUOpE(MDUOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .MDUReadyE(MDUReadyE), .HiE(HiE), .LoE(LoE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vecT;

  typedef struct {
    logic [W-1:0] hi, lo;
    int           stall;
  } expT;

  expT          sb[$];
  vecT          vecs[$];
  logic [W-1:0] curHi, curLo;
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int expStall(input logic [2:0] op);
    if (op[2]) return 0;
`ifdef MDU_FAST_MUL_EN
    if (!op[1]) return 0;
`endif
    return W + 1;
  endfunction

  // Reference behaviour built on the simulator's own arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       p;
    logic [63:0]  pu;
    int           sa, sbv;
    logic [W-1:0] hi, lo;
    hi = curHi;
    lo = curLo;
    sa = $signed(a);
    sbv = $signed(b);
    case (op)
      3'b000: begin p = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = p; end
      3'b001: begin pu = {32'b0, a} * {32'b0, b}; {hi, lo} = pu; end
      3'b010: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
        else begin lo = W'(sa / sbv); hi = W'(sa % sbv); end
      end
      3'b011: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      3'b100: hi = a;
      3'b101: lo = a;
      default: ;
    endcase
    return {hi, lo};
  endfunction

  // Drive one op, hold start while stalled (scrambling inputs), then compare against the queue head.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo);
    expT e;
    int  stall;
    e.hi = hi;
    e.lo = lo;
    e.stall = expStall(op);
    sb.push_back(e);
    @(negedge clk);
    MDUStartE = 1'b1;
    MDUOpE = op;
    SrcAE = a;
    SrcBE = b;
    #1;
    stall = 0;
    while (!MDUReadyE && stall < 200) begin
      stall++;
      @(posedge clk);
      #1;
      SrcAE = $urandom;
      SrcBE = $urandom;
      MDUOpE = 3'($urandom_range(0, 5));
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    MDUStartE = 1'b0;
    e = sb.pop_front();
    check($sformatf("stall op%0d", op), 64'(stall), 64'(e.stall));
    check($sformatf("hi op%0d a=%0h b=%0h", op, a, b), 64'(HiE), 64'(e.hi));
    check($sformatf("lo op%0d a=%0h b=%0h", op, a, b), 64'(LoE), 64'(e.lo));
    curHi = e.hi;
    curLo = e.lo;
  endtask

  task automatic runModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] r;
    r = model(op, a, b);
    issue(op, a, b, r[63:32], r[31:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
    vecs.push_back('{3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF});
    vecs.push_back('{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{3'b001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006});
    vecs.push_back('{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{3'b000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000});

    rst_n = 1'b0;
    MDUStartE = 1'b1;
    MDUOpE = 3'b000;
    SrcAE = 32'd5;
    SrcBE = 32'd7;
    #12;
    check("reset ready", 64'(MDUReadyE), 64'd1);
    check("reset hi", 64'(HiE), 64'd0);
    check("reset lo", 64'(LoE), 64'd0);
    MDUStartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    curHi = '0;
    curLo = '0;

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
      runModel(3'($urandom_range(0, 3)), a, b);
    end

    runModel(3'b100, 32'hAAAA_5555, 32'h0);
    runModel(3'b101, 32'h0000_0001, 32'h0);
    runModel(3'b110, 32'h1111_1111, 32'h2222_2222);

    // Abort a DIV with an asynchronous reset ten cycles into BUSY.
    @(negedge clk);
    MDUStartE = 1'b1;
    MDUOpE = 3'b010;
    SrcAE = 32'd100;
    SrcBE = 32'd7;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort ready", 64'(MDUReadyE), 64'd1);
    check("abort hi", 64'(HiE), 64'd0);
    check("abort lo", 64'(LoE), 64'd0);
    MDUStartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    curHi = '0;
    curLo = '0;
    runModel(3'b011, 32'd100, 32'd7);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
